glitch_pulse_gen: RTL

- Consumes the one-cycle trigger and the stop request produced by the glitcher handler.
- Converts them into the physical glitch waveform: up to two pulses of programmable width, each after a programmable delay.
- Sits between the handler and the glitch output pin inside the glitcher IP.
- Parameters are taken from the same AXI registers that feed the handler: 1st delay, 2nd delay, pulse width.

---
 rtl/glitcher_pkg.sv | 15 +
 rtl/glitch_down_counter.sv | 36 +++
 rtl/glitch_pulse_gen.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/glitcher_pkg.sv
// Shared definitions for the glitcher IP.
// Holds the pulse-generator state encoding, which is also exposed on o_STATE.
package glitcher_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 3'd0,
    ST_DELAY1 = 3'd1,
    ST_PULSE1 = 3'd2,
    ST_DELAY2 = 3'd3,
    ST_PULSE2 = 3'd4
  } pg_state_e;

endpackage

// File: rtl/glitch_down_counter.sv
// Loadable down-counter that saturates at zero.
// Used for both the delay phases and the pulse-width phases of the glitch sequence.
module glitch_down_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/glitch_pulse_gen.sv
// Turns a handler trigger into up to two delayed glitch pulses of equal width.
// A low stop request aborts a running sequence on the next edge.
module glitch_pulse_gen
  import glitcher_pkg::*;
#(
  parameter int unsigned CNT_W         = 32,
  parameter logic        GLITCH_ACTIVE = 1'b1,
  parameter int unsigned PCNT_W        = 16
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_TRIGGER,
  input  logic              i_STOP_N,
  input  logic [CNT_W-1:0]  i_DELAY_1ST,
  input  logic [CNT_W-1:0]  i_DELAY_2ND,
  input  logic [CNT_W-1:0]  i_PULSE_WIDTH,
  input  logic              i_CLR,
  output logic              o_GLITCH,
  output logic              o_BUSY,
  output logic              o_DONE,
  output logic              o_MISSED,
  output logic              o_ABORTED,
  output logic [PCNT_W-1:0] o_PULSE_CNT,
  output logic [2:0]        o_STATE
);

  pg_state_e         state_q;
  logic [CNT_W-1:0]  d2_q;
  logic [CNT_W-1:0]  w_q;
  logic              glitch_q;
  logic              busy_q;
  logic              done_q;
  logic              missed_q;
  logic              aborted_q;
  logic [PCNT_W-1:0] pcnt_q;

  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_zero;
  logic [CNT_W-1:0]  cnt_val;

  logic              start_ok;
  logic              no_pulse;
  logic              abort;
  logic              pulse_end;

  always_comb begin
    start_ok  = i_TRIGGER && i_STOP_N;
    no_pulse  = (i_PULSE_WIDTH == '0) || ((i_DELAY_1ST == '0) && (i_DELAY_2ND == '0));
    abort     = !i_STOP_N && (state_q inside {ST_DELAY1, ST_PULSE1, ST_DELAY2, ST_PULSE2});
    // A pulse cut short by the stop request is not a completed pulse.
    pulse_end = cnt_zero && i_STOP_N && ((state_q == ST_PULSE1) || (state_q == ST_PULSE2));

    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok && !no_pulse) begin
          cnt_load = 1'b1;
          cnt_val  = (i_DELAY_1ST != '0) ? (i_DELAY_1ST - CNT_W'(1))
                                         : (i_DELAY_2ND - CNT_W'(1));
        end
      end
      ST_DELAY1, ST_DELAY2: begin
        if (cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = w_q - CNT_W'(1);
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_PULSE1: begin
        if (cnt_zero && (d2_q != '0)) begin
          cnt_load = 1'b1;
          cnt_val  = d2_q - CNT_W'(1);
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_PULSE2: cnt_en = 1'b1;
      default: ;
    endcase
  end

  glitch_down_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i      (i_CLK),
    .rst_i      (i_RST),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q   <= ST_IDLE;
      d2_q      <= '0;
      w_q       <= '0;
      glitch_q  <= ~GLITCH_ACTIVE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      missed_q  <= 1'b0;
      aborted_q <= 1'b0;
      pcnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            if (no_pulse) begin
              done_q <= 1'b1;
            end else begin
              d2_q    <= i_DELAY_2ND;
              w_q     <= i_PULSE_WIDTH;
              busy_q  <= 1'b1;
              state_q <= (i_DELAY_1ST != '0) ? ST_DELAY1 : ST_DELAY2;
            end
          end
        end
        ST_DELAY1: begin
          if (cnt_zero) begin
            state_q  <= ST_PULSE1;
            glitch_q <= GLITCH_ACTIVE;
          end
        end
        ST_PULSE1: begin
          if (cnt_zero) begin
            glitch_q <= ~GLITCH_ACTIVE;
            if (d2_q != '0) begin
              state_q <= ST_DELAY2;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DELAY2: begin
          if (cnt_zero) begin
            state_q  <= ST_PULSE2;
            glitch_q <= GLITCH_ACTIVE;
          end
        end
        ST_PULSE2: begin
          if (cnt_zero) begin
            state_q  <= ST_IDLE;
            glitch_q <= ~GLITCH_ACTIVE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          glitch_q <= ~GLITCH_ACTIVE;
          busy_q   <= 1'b0;
        end
      endcase

      // Stop overrides whatever the phase logic chose above, including a natural finish.
      if (abort) begin
        state_q  <= ST_IDLE;
        glitch_q <= ~GLITCH_ACTIVE;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
      end

      if (i_CLR) begin
        missed_q  <= 1'b0;
        aborted_q <= 1'b0;
        pcnt_q    <= '0;
      end else begin
        if (i_TRIGGER && (state_q != ST_IDLE)) missed_q <= 1'b1;
        if (abort) aborted_q <= 1'b1;
        if (pulse_end) pcnt_q <= pcnt_q + PCNT_W'(1);
      end
    end
  end

  assign o_GLITCH    = glitch_q;
  assign o_BUSY      = busy_q;
  assign o_DONE      = done_q;
  assign o_MISSED    = missed_q;
  assign o_ABORTED   = aborted_q;
  assign o_PULSE_CNT = pcnt_q;
  assign o_STATE     = state_q;

endmodule
